md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 20 ++
 rtl/md_div.sv | 34 +++
 rtl/md_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, latencies, FSM states.
// Optional divide datapath is enabled by defining MD_DIV_EN.
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/md_div.sv
// Combinational 32-bit divider: signed (truncating) or unsigned quotient/remainder.
// Instantiated by md_unit only when MD_DIV_EN is defined.
module md_div (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic [31:0] q,
    output logic [31:0] r
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ua    = neg_a ? -a : a;
        ub    = neg_b ? -b : b;
        uq    = '0;
        ur    = '0;
        if (ub != '0) begin
            uq = ua / ub;
            ur = ua % ub;
        end
        // quotient sign from both operands, remainder follows the dividend
        q = (neg_a ^ neg_b) ? -uq : uq;
        r = neg_a ? -ur : ur;
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit with MTHI/MTLO moves.
// Define MD_DIV_EN to build the divide datapath; otherwise DIV/DIVU are no-ops.
module md_unit
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_e      state;
    state_e      state_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        load;
    logic        is_mul;
    logic        is_div;
    logic        sgn_m;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] prod;

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign busy   = (state == RUN);

    // one 64-bit multiplier; sign-extending first makes the low 64 bits signed-correct
    assign sgn_m = (op_q == OP_MULT);
    assign ea    = {{32{sgn_m & a_q[31]}}, a_q};
    assign eb    = {{32{sgn_m & b_q[31]}}, b_q};
    assign prod  = ea * eb;

`ifdef MD_DIV_EN
    logic [31:0] div_q;
    logic [31:0] div_r;

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    md_div u_div (
        .a   (a_q),
        .b   (b_q),
        .sgn (op_q == OP_DIV),
        .q   (div_q),
        .r   (div_r)
    );
`else
    assign is_div = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi;
        lo_n    = lo;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul || is_div) begin
                        load    = 1'b1;
                        state_n = RUN;
                        cnt_n   = is_mul ? MUL_CNT : DIV_CNT;
                    end else if (op == OP_MTHI) begin
                        hi_n = a;
                    end else if (op == OP_MTLO) begin
                        lo_n = a;
                    end
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_n = IDLE;
`ifdef MD_DIV_EN
                    if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
                        {hi_n, lo_n} = prod;
                    end else if (b_q != '0) begin
                        hi_n = div_r;
                        lo_n = div_q;
                    end
`else
                    {hi_n, lo_n} = prod;
`endif
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            if (load) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
        end
    end

endmodule
